dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single synchronous data memory (dmem, 2048 x 32) between the CPU load/store port and a DMA/debug port. It sits between the memory stage and the dmem array. It decides the grant each cycle, forwards one access to memory, and returns read data one cycle later to the port that issued it. It also supports locked DMA bursts and, optionally, starvation-free DMA access.

---
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter in front of the 2048x32 synchronous dmem
// Optional starvation guard for the DMA port: define DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
    parameter int DBITS        = 32,
    parameter int DMEMADDRBITS = 13,
    parameter int DMEMWORDBITS = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cpu_req,
    input  logic                                 cpu_we,
    input  logic [DBITS-1:0]                     cpu_addr,
    input  logic [DBITS-1:0]                     cpu_wdata,
    output logic                                 cpu_gnt,
    output logic                                 cpu_rvalid,
    output logic [DBITS-1:0]                     cpu_rdata,
    input  logic                                 dma_req,
    input  logic                                 dma_we,
    input  logic                                 dma_lock,
    input  logic [DBITS-1:0]                     dma_addr,
    input  logic [DBITS-1:0]                     dma_wdata,
    output logic                                 dma_gnt,
    output logic                                 dma_rvalid,
    output logic [DBITS-1:0]                     dma_rdata,
    output logic                                 mem_en,
    output logic                                 mem_we,
    output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_addr,
    output logic [DBITS-1:0]                     mem_wdata,
    input  logic [DBITS-1:0]                     mem_rdata
);

    localparam logic [DBITS-1:0] BAD_DATA = DBITS'(32'hDEADBEEF);

    typedef enum logic {IDLE, DMA_LOCKED} owner_t;

    owner_t owner, owner_nxt;
    logic   force_dma;

`ifdef DMEM_ARB_STARVE_EN
    localparam int SCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

    logic [SCW-1:0] starve_cnt;

    // Counts consecutive cycles the DMA port asked and lost; saturates at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!dma_req || dma_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign force_dma = dma_req && (starve_cnt == STARVE_MAX);
`else
    localparam int unused_starve_limit = STARVE_LIMIT;

    assign force_dma = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner <= IDLE;
        end else begin
            owner <= owner_nxt;
        end
    end

    always_comb begin
        cpu_gnt   = 1'b0;
        dma_gnt   = 1'b0;
        owner_nxt = owner;
        case (owner)
            IDLE: begin
                if (force_dma) begin
                    dma_gnt = 1'b1;
                end else if (cpu_req) begin
                    cpu_gnt = 1'b1;
                end else if (dma_req) begin
                    dma_gnt = 1'b1;
                end
                if (dma_gnt && dma_lock) begin
                    owner_nxt = DMA_LOCKED;
                end
            end
            DMA_LOCKED: begin
                // The lock holds only while the DMA keeps asking and keeps lock raised.
                dma_gnt = dma_req;
                if (!dma_req || !dma_lock) begin
                    owner_nxt = IDLE;
                end
            end
            default: owner_nxt = IDLE;
        endcase
    end

    logic [DBITS-1:0] sel_addr;
    logic [DBITS-1:0] sel_wdata;
    logic             sel_we;
    logic             in_range;
    logic             unused_addr_bits;

    assign sel_addr         = dma_gnt ? dma_addr  : cpu_addr;
    assign sel_wdata        = dma_gnt ? dma_wdata : cpu_wdata;
    assign sel_we           = dma_gnt ? dma_we    : cpu_we;
    assign in_range         = (sel_addr[DBITS-1:DMEMADDRBITS] == '0);
    assign unused_addr_bits = ^sel_addr[DMEMWORDBITS-1:0];

    // Out-of-range accesses are granted but never reach the array.
    assign mem_en    = (cpu_gnt | dma_gnt) & in_range;
    assign mem_we    = mem_en & sel_we;
    assign mem_addr  = sel_addr[DMEMADDRBITS-1:DMEMWORDBITS];
    assign mem_wdata = sel_wdata;

    logic rd_in_range;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rvalid  <= 1'b0;
            dma_rvalid  <= 1'b0;
            rd_in_range <= 1'b0;
        end else begin
            cpu_rvalid  <= cpu_gnt & ~cpu_we;
            dma_rvalid  <= dma_gnt & ~dma_we;
            rd_in_range <= in_range;
        end
    end

    logic [DBITS-1:0] rd_data;

    assign rd_data   = rd_in_range ? mem_rdata : BAD_DATA;
    assign cpu_rdata = cpu_rvalid ? rd_data : '0;
    assign dma_rdata = dma_rvalid ? rd_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural memory/arbitration model
module tb_dmem_arbiter;

    localparam int STARVE_LIMIT = 4;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        mem_en, mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    dmem_arbiter #(
        .DBITS(32), .DMEMADDRBITS(13), .DMEMWORDBITS(2), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] ram [0:2047];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        cpu_q[$];
    exp_t        dma_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_mem [0:2047];
    bit          locked_m;
    int          waited_m;
    bit          last_cpu_g, last_dma_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        chk("rvalid_exclusive", 32'(cpu_rvalid & dma_rvalid), 32'd0);
        if (cpu_rvalid) begin
            if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
                chk("cpu_rdata", cpu_rdata, cpu_q[0].data);
                void'(cpu_q.pop_front());
            end else chk("cpu_rvalid_unexpected", 32'd1, 32'd0);
        end else if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
            chk("cpu_rvalid_missing", 32'd0, 32'd1);
            void'(cpu_q.pop_front());
        end
        if (dma_rvalid) begin
            if (dma_q.size() > 0 && dma_q[0].due == cyc) begin
                chk("dma_rdata", dma_rdata, dma_q[0].data);
                void'(dma_q.pop_front());
            end else chk("dma_rvalid_unexpected", 32'd1, 32'd0);
        end else if (dma_q.size() > 0 && dma_q[0].due == cyc) begin
            chk("dma_rvalid_missing", 32'd0, 32'd1);
            void'(dma_q.pop_front());
        end
    end

    // Apply one cycle of stimulus, predict grant and memory strobe, check, and queue expected read data.
    task automatic drive_check(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                               input logic dr, input logic dw, input logic dl,
                               input logic [31:0] da, input logic [31:0] dd);
        bit          e_cpu, e_dma, we, inr;
        logic [31:0] a, wd, rd;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_lock = dl; dma_addr = da; dma_wdata = dd;
        #1;
        e_cpu = 1'b0;
        e_dma = 1'b0;
        if (locked_m)                                          e_dma = dr;
        else if (STARVE_ON && dr && waited_m >= STARVE_LIMIT)  e_dma = 1'b1;
        else if (cr)                                           e_cpu = 1'b1;
        else if (dr)                                           e_dma = 1'b1;
        chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cpu));
        chk("dma_gnt", 32'(dma_gnt), 32'(e_dma));
        if (e_cpu || e_dma) begin
            a   = e_dma ? da : ca;
            wd  = e_dma ? dd : cd;
            we  = e_dma ? dw : cw;
            inr = (a[31:13] == 19'd0);
            chk("mem_en", 32'(mem_en), 32'(inr));
            chk("mem_we", 32'(mem_we), 32'(inr & we));
            if (inr) chk("mem_addr", 32'(mem_addr), 32'(a[12:2]));
            if (inr && we) chk("mem_wdata", mem_wdata, wd);
            if (we) begin
                if (inr) ref_mem[a[12:2]] = wd;
            end else begin
                rd = inr ? ref_mem[a[12:2]] : 32'hDEADBEEF;
                if (e_dma) dma_q.push_back('{cyc + 1, rd});
                else       cpu_q.push_back('{cyc + 1, rd});
            end
        end else begin
            chk("mem_en_idle", 32'(mem_en), 32'd0);
            chk("mem_we_idle", 32'(mem_we), 32'd0);
        end
        if (e_dma)    locked_m = dl;
        else if (!dr) locked_m = 1'b0;
        waited_m   = (dr && !e_dma) ? waited_m + 1 : 0;
        last_cpu_g = e_cpu;
        last_dma_g = e_dma;
    endtask

    task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw, input logic dl,
                        input logic [31:0] da, input logic [31:0] dd);
        drive_check(cr, cw, ca, cd, dr, dw, dl, da, dd);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        if ($urandom_range(0, 9) == 0) begin
            r = $urandom | 32'h0001_0000;
        end else begin
            r = {21'd0, 5'($urandom_range(0, 31)), 4'd0, 2'($urandom_range(0, 3))};
            r = {r[31:8], 2'b00, r[5:4], r[1:0]} | (32'($urandom_range(0, 31)) << 2);
        end
        return r;
    endfunction

    logic        c_req_r, c_we_r, d_req_r, d_we_r, d_lock_r;
    logic [31:0] c_addr_r, c_wd_r, d_addr_r, d_wd_r;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            ref_mem[i] = $urandom;
            ram[i]     = ref_mem[i];
        end
        mem_rdata = 32'd0;
        locked_m  = 1'b0;
        waited_m  = 0;
        reset     = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 0; dma_wdata = 0;
        repeat (2) @(negedge clk);
        chk("reset_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("reset_dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk("reset_cpu_rdata", cpu_rdata, 32'd0);
        chk("reset_dma_rdata", dma_rdata, 32'd0);
        chk("reset_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("reset_dma_gnt", 32'(dma_gnt), 32'd0);
        reset = 1'b0;

        // CPU write then read back
        step(1, 1, 32'h100, 32'h1234ABCD, 0, 0, 0, 0, 0);
        step(1, 0, 32'h100, 32'h0, 0, 0, 0, 0, 0);
        chk("t1_readback", cpu_rdata, 32'h1234ABCD);

        // Simultaneous requests: CPU first, then DMA once CPU drops
        step(1, 0, 32'h200, 0, 1, 0, 0, 32'h204, 0);
        step(0, 0, 32'h0, 0, 1, 0, 0, 32'h204, 0);

        // Locked DMA burst with CPU waiting
        step(0, 0, 32'h0, 0, 1, 0, 1, 32'h300, 0);
        step(1, 0, 32'h104, 0, 1, 0, 1, 32'h304, 0);
        step(1, 0, 32'h104, 0, 1, 0, 1, 32'h308, 0);
        step(1, 0, 32'h104, 0, 1, 0, 0, 32'h30C, 0);
        step(1, 0, 32'h104, 0, 0, 0, 0, 32'h0, 0);

        // Both ports held: starvation guard behaviour
        for (int i = 0; i < 12; i++) step(1, 0, 32'h108, 0, 1, 0, 0, 32'h208, 0);
        step(0, 0, 32'h0, 0, 1, 0, 0, 32'h208, 0);

        // Out-of-range CPU read
        step(1, 0, 32'hF0000014, 0, 0, 0, 0, 0, 0);
        chk("t5_oor_rdata", cpu_rdata, 32'hDEADBEEF);

        // Reset during a locked burst with a read in flight
        step(0, 0, 32'h0, 0, 1, 0, 1, 32'h310, 0);
        drive_check(0, 0, 32'h0, 0, 1, 0, 1, 32'h314, 0);
        #1;
        reset = 1'b1;
        cpu_q.delete();
        dma_q.delete();
        locked_m = 1'b0;
        waited_m = 0;
        cpu_req = 0; dma_req = 0; dma_lock = 0;
        #1;
        chk("t6_dma_rvalid_in_reset", 32'(dma_rvalid), 32'd0);
        @(negedge clk);
        chk("t6_dma_rvalid_after_edge", 32'(dma_rvalid), 32'd0);
        reset = 1'b0;
        step(1, 0, 32'h100, 0, 1, 0, 0, 32'h314, 0);
        step(0, 0, 32'h0, 0, 1, 0, 0, 32'h314, 0);

        // Randomized traffic; requesters hold their request until granted
        c_req_r = 0; d_req_r = 0;
        last_cpu_g = 0; last_dma_g = 0;
        c_we_r = 0; c_addr_r = 0; c_wd_r = 0;
        d_we_r = 0; d_lock_r = 0; d_addr_r = 0; d_wd_r = 0;
        for (int i = 0; i < 400; i++) begin
            if (!c_req_r || last_cpu_g) begin
                c_req_r  = ($urandom_range(0, 99) < 55);
                c_we_r   = 1'($urandom_range(0, 1));
                c_addr_r = rand_addr();
                c_wd_r   = $urandom;
            end
            if (!d_req_r || last_dma_g) begin
                d_req_r  = ($urandom_range(0, 99) < 60);
                d_we_r   = 1'($urandom_range(0, 1));
                d_lock_r = ($urandom_range(0, 3) == 0);
                d_addr_r = rand_addr();
                d_wd_r   = $urandom;
            end
            step(c_req_r, c_we_r, c_addr_r, c_wd_r, d_req_r, d_we_r, d_lock_r, d_addr_r, d_wd_r);
        end

        repeat (3) step(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0);
        chk("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
        chk("dma_queue_drained", 32'(dma_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
